// File: rtl/reg_port_ctrl.sv
// Register-file port initiator: serialises two-source operand reads and single
// writebacks onto one RegRead/RegWrite port. Optional macro: REGPORT_SAME_SRC_EN.
module reg_port_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rs1_data,
  output logic [XLEN-1:0] rsp_rs2_data,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            RegRead,
  output logic            RegWrite,
  output logic [AW-1:0]   regno,
  output logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, CAP2, RSP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] rs1_q, rs2_q;
  logic          req_fire;

  function automatic logic [XLEN-1:0] zero_x0(input logic [AW-1:0] idx,
                                              input logic [XLEN-1:0] d);
    return (idx == '0) ? '0 : d;
  endfunction

  assign rsp_valid = (state == RSP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // All port outputs are gated by rst so the port goes quiet the moment reset rises.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    wb_ready  = 1'b0;
    RegRead   = 1'b0;
    RegWrite  = 1'b0;
    regno     = '0;
    wdata     = '0;
    req_fire  = 1'b0;
    if (!rst) begin
      if ((state == IDLE || state == RSP) && wb_valid) begin
        wb_ready = 1'b1;
        if (wb_rd != '0) begin
          RegWrite = 1'b1;
          regno    = wb_rd;
          wdata    = wb_data;
        end
      end
      case (state)
        IDLE: begin
          if (!wb_valid) begin
            req_ready = 1'b1;
            if (req_valid) begin
              req_fire  = 1'b1;
              state_nxt = RD1;
            end
          end
        end
        RD1: begin
          RegRead   = 1'b1;
          regno     = rs1_q;
          state_nxt = RD2;
`ifdef REGPORT_SAME_SRC_EN
          if (rs1_q == rs2_q) state_nxt = CAP2;
`endif
        end
        RD2: begin
          RegRead   = 1'b1;
          regno     = rs2_q;
          state_nxt = CAP2;
        end
        CAP2: state_nxt = RSP;
        RSP: begin
          if (rsp_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // rdata lags RegRead by one cycle: rs1 lands during RD2, rs2 during CAP2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q        <= '0;
      rs2_q        <= '0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else begin
      if (req_fire) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
      end
      if (state == RD2) rsp_rs1_data <= zero_x0(rs1_q, rdata);
      if (state == CAP2) begin
        rsp_rs2_data <= zero_x0(rs2_q, rdata);
`ifdef REGPORT_SAME_SRC_EN
        if (rs1_q == rs2_q) rsp_rs1_data <= zero_x0(rs1_q, rdata);
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_port_ctrl.sv
// Scoreboard bench for reg_port_ctrl with a behavioural register file on the port.
module tb_reg_port_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 5;
`ifdef REGPORT_SAME_SRC_EN
  localparam bit SAME = 1'b1;
`else
  localparam bit SAME = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0]   req_rs1, req_rs2, wb_rd, regno;
  logic [XLEN-1:0] rsp_rs1_data, rsp_rs2_data, wb_data, wdata, rdata;
  logic            wb_valid, wb_ready, RegRead, RegWrite;

  reg_port_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .RegRead(RegRead), .RegWrite(RegWrite), .regno(regno), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    int              reads;
    int              lat;
  } exp_t;

  exp_t            q[$];
  logic [XLEN-1:0] mem    [32];
  logic [XLEN-1:0] shadow [32];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc, reads;
  bit seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register file: no x0 semantics; index 0 reads all-ones, unread cycles return junk.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rdata <= 32'hBAD0BAD0;
    end else begin
      if (RegWrite) mem[regno] <= wdata;
      if (RegRead) rdata <= (regno == '0) ? '1 : mem[regno];
      else         rdata <= 32'hBAD0BAD0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      seen = 1'b0;
      for (int i = 0; i < 32; i++) shadow[i] = '0;
    end else begin
      if (RegRead || RegWrite) chk("strobe_excl", {RegRead, RegWrite} == 2'b11, 0);
      if (wb_valid && wb_ready) begin
        if (wb_rd != '0) begin
          chk("wb_write", {RegWrite, regno, wdata}, {1'b1, wb_rd, wb_data});
          shadow[wb_rd] = wb_data;
        end else begin
          chk("wb_x0_drop", RegWrite, 0);
        end
      end else if (RegWrite) begin
        chk("stray_write", RegWrite, 0);
      end
      if (RegRead) reads++;
      if (req_valid && req_ready) begin
        e.d1    = shadow[req_rs1];
        e.d2    = shadow[req_rs2];
        e.reads = (SAME && req_rs1 == req_rs2) ? 1 : 2;
        e.lat   = (SAME && req_rs1 == req_rs2) ? 3 : 4;
        q.push_back(e);
        hs_cyc = cyc;
        reads  = 0;
        seen   = 1'b0;
      end
      if (rsp_valid && !seen && q.size() > 0) begin
        seen = 1'b1;
        chk("latency", cyc - hs_cyc, q[0].lat);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rs1_data", rsp_rs1_data, e.d1);
          chk("rs2_data", rsp_rs2_data, e.d2);
          chk("read_cycles", reads, e.reads);
        end
      end
    end
  end

  task automatic do_wb(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    bit ok = 1'b0;
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    if (!ok) chk("wb_timeout", 0, 1);
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [AW-1:0] b);
    bit ok = 1'b0;
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input bit rand_bp);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0) begin ok = 1'b1; break; end
      rsp_ready = rand_bp ? 1'($urandom_range(1)) : 1'b1;
    end
    rsp_ready = 1'b1;
    if (!ok) begin
      chk("rsp_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 0; req_rs1 = 0; req_rs2 = 0; rsp_ready = 1'b1;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    repeat (3) @(posedge clk);
    #1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1;
    @(negedge clk);
    chk("rst_outputs", {rsp_valid, RegRead, RegWrite, regno, wdata}, '0);
    chk("rst_rsp_data", {rsp_rs1_data, rsp_rs2_data}, '0);
    chk("rst_ready", {req_ready, wb_ready}, 2'b00);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Write r5 then read it back with x0 as the second source.
    do_wb(5'd5, 32'hDEADBEEF);
    do_req(5'd5, 5'd0);
    wait_rsp(0);

    // Writes to x0 are acknowledged but dropped.
    do_wb(5'd0, 32'h1234);
    do_req(5'd0, 5'd0);
    wait_rsp(0);

    // Simultaneous wb and req in IDLE: wb wins, req goes next cycle.
    do_wb(5'd3, 32'hA);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd3;
    @(negedge clk);
    chk("both_req_ready", req_ready, 0);
    chk("both_wb_ready", wb_ready, 1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("req_after_wb", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(0);

    // Backpressure with a write to the held source during RSP.
    rsp_ready = 1'b0;
    do_req(5'd3, 5'd0);
    wait_valid();
    do_wb(5'd3, 32'h99);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_rs1_data, 32'hA);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_rsp(0);
    do_req(5'd3, 5'd7);
    wait_rsp(0);

    // Response handshake and writeback completing in the same RSP cycle.
    rsp_ready = 1'b0;
    do_req(5'd7, 5'd5);
    wait_valid();
    rsp_ready = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1111;
    @(negedge clk);
    chk("rsp_wb_ready", {rsp_valid, wb_ready}, 2'b11);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    chk("rsp_wb_done", q.size(), 0);
    do_req(5'd5, 5'd5);
    wait_rsp(0);

    // Reset asserted in RD2 kills the read at once.
    do_req(5'd1, 5'd2);
    @(posedge clk); #1;
    chk("rd2_reading", {RegRead, regno}, {1'b1, 5'd2});
    rst = 1'b1;
    #1;
    chk("rst_drop_read", {RegRead, RegWrite}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {rsp_valid, req_ready, RegRead}, 3'b010);
    @(posedge clk); #1;

    // Equal sources.
    do_wb(5'd9, 32'h77);
    do_req(5'd9, 5'd9);
    wait_rsp(0);

    // Random mix with random backpressure.
    for (int n = 0; n < 20; n++) begin
      do_wb(5'($urandom_range(31)), $urandom);
      do_req(5'($urandom_range(31)), 5'($urandom_range(31)));
      wait_rsp(1);
    end
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_port_ctrl.md
Name: reg_port_ctrl

Overview:
- Initiator side of the single-port register file interface (RegRead/RegWrite/regno/wdata/rdata).
- Accepts a two-source operand-read request from decode and a one-destination writeback request from WB.
- Serialises both onto the single register file port and returns rs1/rs2 operands through a valid/ready response.
- Supplies the x0-reads-as-zero / x0-write-ignored semantics that the register file itself does not provide.

Parameters:
XLEN, 32, data width of rdata/wdata/operands
AW, 5, register index width (2**AW registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  operand-read request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_rs1  input  AW  source register 1 index
req_rs2  input  AW  source register 2 index
rsp_valid  output  1  operands valid, held until rsp_ready
rsp_ready  input  1  consumer accepts response
rsp_rs1_data  output  XLEN  operand 1
rsp_rs2_data  output  XLEN  operand 2
wb_valid  input  1  writeback request valid
wb_ready  output  1  writeback accepted when wb_valid && wb_ready
wb_rd  input  AW  destination index
wb_data  input  XLEN  writeback data
RegRead  output  1  register file read strobe
RegWrite  output  1  register file write strobe
regno  output  AW  register file index
wdata  output  XLEN  register file write data
rdata  input  XLEN  register file read data, valid the cycle after RegRead

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rsp_valid=0; rsp_rs1_data=rsp_rs2_data=0; latched rs1/rs2=0.
  - RegRead=RegWrite=0 immediately; regno=0, wdata=0.
- Reset mid-operation: in-flight request and response are discarded, with no further port activity. A wb handshake in the reset cycle does not happen.
- States: IDLE, RD1, RD2, CAP2, RSP.
- IDLE:
  - wb has priority over req.
  - If wb_valid: wb_ready=1 and req_ready=0. If wb_rd!=0, RegWrite=1, regno=wb_rd, wdata=wb_data this cycle. If wb_rd==0, RegWrite stays 0 (write dropped, still acknowledged). Stay in IDLE.
  - Else req_ready=1. On req handshake, latch req_rs1/req_rs2 and go to RD1.
- RD1: RegRead=1, regno=latched rs1 -> RD2.
- RD2: RegRead=1, regno=latched rs2. At the clock edge, capture rdata into rsp_rs1_data (0 if rs1==0) -> CAP2.
- CAP2: RegRead=0. At the clock edge, capture rdata into rsp_rs2_data (0 if rs2==0); set rsp_valid -> RSP.
- RSP:
  - rsp_valid=1; data stable until handshake.
  - Writeback is also accepted here, with the same rules as IDLE, since the port is free.
  - On rsp_valid && rsp_ready: clear rsp_valid -> IDLE. A new req is not accepted in the same cycle; req_ready=0 outside IDLE.
  - Simultaneous rsp handshake and wb in RSP: both complete.
- wb_ready=0 in RD1/RD2/CAP2; wb waits.
- Latency: req handshake at edge N -> rsp_valid high from cycle N+4. Throughput is one request per 5 cycles with no backpressure.
- RAW ordering: a writeback accepted before a req handshake is visible to that read. Operands latched in RSP are not updated by a later writeback.
- RegRead and RegWrite are never asserted in the same cycle. Neither is asserted in CAP2, or in IDLE/RSP without a wb.
- rdata is sampled only at the RD2 and CAP2 edges; X on rdata at other times is ignored.
- Indices are AW bits, no wrap logic. Data passes through unmodified.

Optional Feature:
- Macro: REGPORT_SAME_SRC_EN.
- Defined: when the latched rs1==rs2, RD1 goes directly to CAP2 with one read only. At the CAP2 edge, rdata is captured into both operands (0 if index 0). Latency becomes N+3 for equal sources.
- Undefined: always two reads; latency is N+4 regardless.

Test Plan:
- Write 0xDEADBEEF to r5 via wb, then req rs1=5, rs2=0 -> RegWrite pulse with regno=5; rsp_rs1_data=0xDEADBEEF, rsp_rs2_data=0; rsp_valid at handshake+4.
- wb to r0 with 0x1234, then req rs1=0, rs2=0 -> wb_ready=1, RegWrite never asserted; both operands 0.
- req_valid and wb_valid together in IDLE (wb r7=0x55) with req rs1=7, rs2=3 (r3=0xA) -> write first, req_ready=0 that cycle; next cycle req accepted; operands 0x55 and 0xA.
- rsp_ready held low 6 cycles with wb r3=0x99 during RSP -> rsp stays valid with old r3 value 0xA; write completes in RSP; the next request reads 0x99.
- Assert rst in the RD2 cycle -> RegRead drops immediately; after release, state IDLE, rsp_valid=0, req_ready=1.
- With REGPORT_SAME_SRC_EN: req rs1=rs2=9 (r9=0x77) -> exactly one RegRead cycle; both operands 0x77 at handshake+3. Without the macro: two RegRead cycles, result at +4.
